// File: rtl/msrv32_wb_port_arbiter.sv
// Register-file write-port arbiter: the in-order pipeline writeback shares the port with
// buffered late (multi-cycle) results, which drain in idle slots or a forced stall slot.
module msrv32_wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8,
    parameter int CW         = 3
) (
    input  logic          ms_riscv32_mp_clk_in,
    input  logic          ms_riscv32_mp_rst_in,
    input  logic          pipe_wr_en_in,
    input  logic [4:0]    pipe_rd_addr_in,
    input  logic [31:0]   pipe_wr_data_in,
    input  logic          late_valid_in,
    output logic          late_ready_out,
    input  logic [4:0]    late_rd_addr_in,
    input  logic [31:0]   late_data_in,
    input  logic [4:0]    query_rs1_in,
    input  logic [4:0]    query_rs2_in,
    output logic          pending_hit_out,
    output logic          pipe_stall_out,
    output logic [CW-1:0] fifo_count_out,
    output logic          rf_wr_en_out,
    output logic [4:0]    rf_rd_addr_out,
    output logic [31:0]   rf_wr_data_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

    typedef enum logic {NORMAL, DRAIN} state_t;

    state_t           state_r;
    state_t           state_nxt;

    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] slot_vld_r;
    logic [DEPTH-1:0] slot_vld_nxt;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [SW-1:0]    starve_r;
    logic [SW-1:0]    starve_nxt;

    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             pipe_req;

    logic             wr_en_p0;
    logic [4:0]       rd_p0;
    logic [31:0]      data_p0;
    logic             vld_p1;
    logic [4:0]       rd_p1;
    logic [31:0]      data_p1;

    // Ready depends on registered occupancy only, so a same-cycle pop never frees a slot.
    assign fifo_empty     = (count_r == '0);
    assign late_ready_out = (count_r < CW'(DEPTH));
    assign push           = late_valid_in && late_ready_out && (late_rd_addr_in != 5'd0);
    assign pipe_req       = pipe_wr_en_in && (pipe_rd_addr_in != 5'd0);

    always_comb begin
        state_nxt  = state_r;
        starve_nxt = starve_r;
        pop        = 1'b0;
        wr_en_p0   = 1'b0;
        rd_p0      = rd_mem[rd_ptr_r];
        data_p0    = data_mem[rd_ptr_r];
        case (state_r)
            NORMAL: begin
                if (pipe_req) begin
                    wr_en_p0 = 1'b1;
                    rd_p0    = pipe_rd_addr_in;
                    data_p0  = pipe_wr_data_in;
                end else if (!fifo_empty) begin
                    pop      = 1'b1;
                    wr_en_p0 = 1'b1;
                end
                if (fifo_empty || pop) begin
                    starve_nxt = '0;
                end else if (starve_r == SW'(STARVE_MAX - 1)) begin
                    state_nxt  = DRAIN;
                    starve_nxt = '0;
                end else begin
                    starve_nxt = starve_r + SW'(1);
                end
            end
            DRAIN: begin
                pop        = !fifo_empty;
                wr_en_p0   = !fifo_empty;
                state_nxt  = NORMAL;
                starve_nxt = '0;
            end
            default: begin
                state_nxt  = NORMAL;
                starve_nxt = '0;
            end
        endcase
    end

    always_comb begin
        slot_vld_nxt = slot_vld_r;
        if (pop) begin
            slot_vld_nxt[rd_ptr_r] = 1'b0;
        end
        if (push) begin
            slot_vld_nxt[wr_ptr_r] = 1'b1;
        end
    end

    // Popped-this-cycle entries stay visible; entries pushed this cycle are not yet valid.
    always_comb begin
        pending_hit_out = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld_r[i] &&
                (((query_rs1_in != 5'd0) && (rd_mem[i] == query_rs1_in)) ||
                 ((query_rs2_in != 5'd0) && (rd_mem[i] == query_rs2_in)))) begin
                pending_hit_out = 1'b1;
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            rd_mem[wr_ptr_r]   <= late_rd_addr_in;
            data_mem[wr_ptr_r] <= late_data_in;
        end
    end

    // p0 -> p1: grant result registered onto the register-file port
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_r    <= NORMAL;
            starve_r   <= '0;
            count_r    <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            slot_vld_r <= '0;
            vld_p1     <= 1'b0;
            rd_p1      <= '0;
            data_p1    <= '0;
        end else begin
            state_r    <= state_nxt;
            starve_r   <= starve_nxt;
            count_r    <= count_r + CW'(push) - CW'(pop);
            slot_vld_r <= slot_vld_nxt;
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            vld_p1 <= wr_en_p0;
            if (wr_en_p0) begin
                rd_p1   <= rd_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign pipe_stall_out = (state_r == DRAIN);
    assign fifo_count_out = count_r;
    assign rf_wr_en_out   = vld_p1;
    assign rf_rd_addr_out = rd_p1;
    assign rf_wr_data_out = data_p1;

endmodule

// File: tb/tb_msrv32_wb_port_arbiter.sv
// Bench for msrv32_wb_port_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_msrv32_wb_port_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int CW         = 3;

    logic          clk;
    logic          rst_n;
    logic          pipe_wr_en;
    logic [4:0]    pipe_rd;
    logic [31:0]   pipe_data;
    logic          late_valid;
    logic          late_ready;
    logic [4:0]    late_rd;
    logic [31:0]   late_data;
    logic [4:0]    q1;
    logic [4:0]    q2;
    logic          hit;
    logic          stall;
    logic [CW-1:0] count;
    logic          rf_en;
    logic [4:0]    rf_rd;
    logic [31:0]   rf_data;

    int errors = 0;
    int checks = 0;

    msrv32_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX), .CW(CW)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .pipe_wr_en_in        (pipe_wr_en),
        .pipe_rd_addr_in      (pipe_rd),
        .pipe_wr_data_in      (pipe_data),
        .late_valid_in        (late_valid),
        .late_ready_out       (late_ready),
        .late_rd_addr_in      (late_rd),
        .late_data_in         (late_data),
        .query_rs1_in         (q1),
        .query_rs2_in         (q2),
        .pending_hit_out      (hit),
        .pipe_stall_out       (stall),
        .fifo_count_out       (count),
        .rf_wr_en_out         (rf_en),
        .rf_rd_addr_out       (rf_rd),
        .rf_wr_data_out       (rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: buffered results as a queue, plus drain flag and starvation count.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      m_q[$];
    int          m_starve;
    bit          m_drain;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [4:0]  seen[$];

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_drain  = 1'b0;
        m_en     = 1'b0;
        m_rd     = 5'd0;
        m_data   = 32'd0;
    endtask

    function automatic bit model_hit();
        bit h = 1'b0;
        foreach (m_q[i]) begin
            if ((q1 != 5'd0 && m_q[i].rd == q1) || (q2 != 5'd0 && m_q[i].rd == q2)) h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_step();
        bit     accept;
        bit     popped;
        bit     was_empty;
        entry_t e;
        accept    = late_valid && (m_q.size() < DEPTH) && (late_rd != 5'd0);
        was_empty = (m_q.size() == 0);
        popped    = 1'b0;
        m_en      = 1'b0;
        if (m_drain) begin
            if (!was_empty) begin
                e = m_q.pop_front();
                m_en = 1'b1; m_rd = e.rd; m_data = e.data;
            end
            m_drain  = 1'b0;
            m_starve = 0;
        end else begin
            if (pipe_wr_en && pipe_rd != 5'd0) begin
                m_en = 1'b1; m_rd = pipe_rd; m_data = pipe_data;
            end else if (!was_empty) begin
                e = m_q.pop_front();
                popped = 1'b1;
                m_en = 1'b1; m_rd = e.rd; m_data = e.data;
            end
            if (was_empty || popped) begin
                m_starve = 0;
            end else begin
                m_starve = m_starve + 1;
                if (m_starve == STARVE_MAX) begin
                    m_drain  = 1'b1;
                    m_starve = 0;
                end
            end
        end
        if (accept) m_q.push_back('{rd: late_rd, data: late_data});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // Called with inputs driven and settled; checks against the model across one edge.
    task automatic cycle();
        chk("ready", 32'(late_ready), 32'(m_q.size() < DEPTH));
        chk("stall", 32'(stall), 32'(m_drain));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("hit", 32'(hit), 32'(model_hit()));
        model_step();
        @(posedge clk);
        #1;
        chk("rf_en", 32'(rf_en), 32'(m_en));
        chk("rf_rd", 32'(rf_rd), 32'(m_rd));
        chk("rf_data", rf_data, m_data);
        if (rf_en) seen.push_back(rf_rd);
    endtask

    task automatic idle_inputs();
        pipe_wr_en = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
        late_valid = 1'b0; late_rd = 5'd0; late_data = 32'd0;
        q1 = 5'd0; q2 = 5'd0;
    endtask

    typedef struct {
        logic        pe;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ready;
        logic        e_stall;
        int          e_count;
        logic        e_hit;
        logic        e_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[10];
    logic [4:0] late_seen[$];

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1234, 5'd7, 5'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 5'd7, 1'b1, 1'b0, 1, 1'b1, 1'b1, 5'd7, 32'h1234};
        vecs[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 5'd7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd7, 32'h1234};
        vecs[4] = '{1'b1, 5'd0, 32'h66,       1'b1, 5'd0, 32'h55,   5'd0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd7, 32'h1234};
        vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd0, 5'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd7, 32'h1234};
        vecs[6] = '{1'b1, 5'd3, 32'hA,        1'b1, 5'd9, 32'h99,   5'd0, 5'd9, 1'b1, 1'b0, 0, 1'b0, 1'b1, 5'd3, 32'hA};
        vecs[7] = '{1'b1, 5'd4, 32'hB,        1'b0, 5'd0, 32'h0,    5'd0, 5'd9, 1'b1, 1'b0, 1, 1'b1, 1'b1, 5'd4, 32'hB};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 5'd0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 5'd9, 32'h99};
        vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,    5'd9, 5'd9, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5'd9, 32'h99};

        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_en", 32'(rf_en), 32'd0);
        chk("reset_rf_rd", 32'(rf_rd), 32'd0);
        chk("reset_rf_data", rf_data, 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_ready", 32'(late_ready), 32'd1);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            pipe_wr_en = vecs[i].pe;  pipe_rd = vecs[i].prd; pipe_data = vecs[i].pd;
            late_valid = vecs[i].lv;  late_rd = vecs[i].lrd; late_data = vecs[i].ld;
            q1 = vecs[i].rs1; q2 = vecs[i].rs2;
            settle();
            chk($sformatf("vec%0d_ready", i), 32'(late_ready), 32'(vecs[i].e_ready));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].e_hit));
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rf_en", i), 32'(rf_en), 32'(vecs[i].e_en));
            chk($sformatf("vec%0d_rf_rd", i), 32'(rf_rd), 32'(vecs[i].e_rd));
            chk($sformatf("vec%0d_rf_data", i), rf_data, vecs[i].e_data);
        end

        // Starvation: pipe writes every cycle, one late entry waits for a forced drain
        idle_inputs();
        pipe_wr_en = 1'b1; pipe_rd = 5'd1; pipe_data = 32'd100;
        late_valid = 1'b1; late_rd = 5'd12; late_data = 32'hC0FFEE;
        settle();
        cycle();
        late_valid = 1'b0;
        for (int k = 1; k <= STARVE_MAX; k++) begin
            pipe_data = 32'(100 + k);
            settle();
            chk("starve_stall_low", 32'(stall), 32'd0);
            cycle();
            chk("starve_pipe_data", rf_data, 32'(100 + k));
        end
        pipe_data = 32'd200;
        settle();
        chk("drain_stall_high", 32'(stall), 32'd1);
        cycle();
        chk("drain_rd", 32'(rf_rd), 32'd12);
        chk("drain_data", rf_data, 32'hC0FFEE);
        settle();
        chk("drain_stall_drop", 32'(stall), 32'd0);
        cycle();
        chk("resume_rd", 32'(rf_rd), 32'd1);
        chk("resume_data", rf_data, 32'd200);
        chk("resume_count", 32'(count), 32'd0);

        // Fill the FIFO while the pipe is busy, hold a fifth result, then drain in order
        seen.delete();
        pipe_wr_en = 1'b1; pipe_rd = 5'd2;
        for (int i = 0; i < DEPTH; i++) begin
            late_valid = 1'b1; late_rd = 5'(20 + i); late_data = 32'(32'h2000 + i);
            pipe_data = 32'(i);
            settle();
            cycle();
        end
        late_rd = 5'd24; late_data = 32'h2004;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("full_ready_low", 32'(late_ready), 32'd0);
            chk("full_count", 32'(count), 32'(DEPTH));
            cycle();
        end
        pipe_wr_en = 1'b0;
        settle();
        chk("pop_on_full_ready_low", 32'(late_ready), 32'd0);
        cycle();
        settle();
        chk("ready_after_pop", 32'(late_ready), 32'd1);
        cycle();
        late_valid = 1'b0;
        repeat (5) begin
            settle();
            cycle();
        end
        late_seen.delete();
        foreach (seen[i]) if (seen[i] >= 5'd20) late_seen.push_back(seen[i]);
        chk("drain_total", 32'(late_seen.size()), 32'd5);
        foreach (late_seen[i]) chk("drain_order", 32'(late_seen[i]), 32'(20 + i));

        // Reset asserted while in DRAIN
        pipe_wr_en = 1'b1; pipe_rd = 5'd6; pipe_data = 32'h77;
        late_valid = 1'b1; late_rd = 5'd13; late_data = 32'h1313;
        settle();
        cycle();
        late_valid = 1'b0;
        for (int k = 1; k <= STARVE_MAX; k++) begin
            settle();
            cycle();
        end
        settle();
        chk("pre_reset_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_stall", 32'(stall), 32'd0);
        chk("midreset_count", 32'(count), 32'd0);
        chk("midreset_rf_en", 32'(rf_en), 32'd0);
        chk("midreset_rf_rd", 32'(rf_rd), 32'd0);
        chk("midreset_rf_data", rf_data, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_inputs();
        settle();
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 2000; n++) begin
            pipe_wr_en = ($urandom_range(0, 9) < 7);
            pipe_rd    = 5'($urandom_range(0, 7));
            pipe_data  = $urandom();
            late_valid = ($urandom_range(0, 9) < 4);
            late_rd    = 5'($urandom_range(0, 7));
            late_data  = $urandom();
            q1         = 5'($urandom_range(0, 7));
            q2         = 5'($urandom_range(0, 7));
            settle();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
